lut_cfg_loader: RTL and testbench

Serial configuration writer for the logic-pair array. It receives a framed bitstream and deserializes it into one 16-bit LUT word plus one FF/LUT `switch` select per logic pair. It drives those values onto the `look_up_t`/`switch` inputs of `NUM_LP` logic pairs, with `prgm_b`/`CLB_prgm_b` strobes. It sits between the chip-level configuration port and the CLB array, and is the producer side of the LUT programming interface.

---
 rtl/lut_cfg_loader_if.sv | 26 ++
 rtl/lut_cfg_loader.sv | 165 ++++++++++++++++
 tb/tb_lut_cfg_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_cfg_loader_if.sv
// Bus between the configuration port and the LUT loader; the loader owns the master side.
// Start/serial inputs flow in, slot contents and program strobes flow out.
interface lut_cfg_loader_if #(
  parameter int NUM_LP = 8
);
  logic                     start;
  logic                     cfg_bit;
  logic                     cfg_valid;
  logic [16*NUM_LP-1:0]     look_up_t;
  logic [NUM_LP-1:0]        switch;
  logic                     prgm_b;
  logic                     CLB_prgm_b;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    input  start, cfg_bit, cfg_valid,
    output look_up_t, switch, prgm_b, CLB_prgm_b, busy, done, err
  );

  modport slave (
    output start, cfg_bit, cfg_valid,
    input  look_up_t, switch, prgm_b, CLB_prgm_b, busy, done, err
  );
endinterface

// File: rtl/lut_cfg_loader.sv
// Serial LUT/switch config writer: sync, frame count, then 17-bit frames (18 with CFG_PARITY_EN).
// Slot visible one cycle after its last bit; cfg_valid gaps simply stall, start ignored while busy.
module lut_cfg_loader #(
  parameter int         NUM_LP    = 8,
  parameter logic [7:0] SYNC_WORD = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  lut_cfg_loader_if.master  bus
);

`ifdef CFG_PARITY_EN
  localparam int FRAME_BITS = 18;
`else
  localparam int FRAME_BITS = 17;
`endif
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);
  localparam logic [7:0] MAX_N    = 8'(NUM_LP);

  typedef enum logic [1:0] {IDLE, SYNC, COUNT, LOAD} state_t;

  state_t                  state;
  logic [7:0]              window;
  logic [4:0]              bit_cnt;
  logic [7:0]              idx;
  logic [7:0]              n_frames;
  logic [FRAME_BITS-2:0]   frame_sr;
  logic [16*NUM_LP-1:0]    lut_q;
  logic [NUM_LP-1:0]       sw_q;
  logic                    prgm_b_q;
  logic                    clb_prgm_b_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  logic [7:0]              window_nxt;
  logic [FRAME_BITS-1:0]   frame_word;
  logic [15:0]             frame_lut;
  logic                    frame_sw;
  logic                    parity_ok;
  logic                    sync_hit;
  logic                    last_frame;
  logic                    bad_count;

  assign window_nxt = {window[6:0], bus.cfg_bit};
  assign frame_word = {frame_sr, bus.cfg_bit};
  assign frame_lut  = frame_word[FRAME_BITS-1 -: 16];
  assign frame_sw   = frame_word[FRAME_BITS-17];
`ifdef CFG_PARITY_EN
  assign parity_ok  = ~^frame_word;
`else
  assign parity_ok  = 1'b1;
`endif
  // A match needs a full window of real bits, so a zero-reset window never fakes a sync.
  assign sync_hit   = (bit_cnt >= 5'd7) && (window_nxt == SYNC_WORD);
  assign last_frame = (idx == n_frames - 8'd1);
  assign bad_count  = (window_nxt == 8'd0) || (window_nxt > MAX_N);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      window       <= '0;
      bit_cnt      <= '0;
      idx          <= '0;
      n_frames     <= '0;
      frame_sr     <= '0;
      lut_q        <= '0;
      sw_q         <= '0;
      prgm_b_q     <= 1'b1;
      clb_prgm_b_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      clb_prgm_b_q <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.start) begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            window   <= '0;
            frame_sr <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            busy_q   <= 1'b1;
            state    <= SYNC;
          end
        end
        SYNC: begin
          if (bus.cfg_valid) begin
            window <= window_nxt;
            if (sync_hit) begin
              bit_cnt <= '0;
              state   <= COUNT;
            end else if (bit_cnt != 5'd8) begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        COUNT: begin
          if (bus.cfg_valid) begin
            window <= window_nxt;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              if (bad_count) begin
                err_q  <= 1'b1;
                busy_q <= 1'b0;
                state  <= IDLE;
              end else begin
                n_frames <= window_nxt;
                prgm_b_q <= 1'b0;
                state    <= LOAD;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        LOAD: begin
          if (bus.cfg_valid) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              frame_sr <= '0;
              if (parity_ok) begin
                for (int k = 0; k < NUM_LP; k++) begin
                  if (idx == 8'(k)) begin
                    lut_q[16*k +: 16] <= frame_lut;
                    sw_q[k]           <= frame_sw;
                  end
                end
                clb_prgm_b_q <= 1'b0;
                idx          <= idx + 8'd1;
                if (last_frame) begin
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  prgm_b_q <= 1'b1;
                  state    <= IDLE;
                end
              end else begin
                // Bad frame is dropped; slots already committed stay valid.
                err_q    <= 1'b1;
                busy_q   <= 1'b0;
                prgm_b_q <= 1'b1;
                state    <= IDLE;
              end
            end else begin
              frame_sr <= frame_word[FRAME_BITS-2:0];
              bit_cnt  <= bit_cnt + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.look_up_t  = lut_q;
  assign bus.switch     = sw_q;
  assign bus.prgm_b     = prgm_b_q;
  assign bus.CLB_prgm_b = clb_prgm_b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Bench for lut_cfg_loader: scoreboard of expected slot commits checked on every CLB_prgm_b pulse.
module tb_lut_cfg_loader;
  localparam int NUM_LP = 8;
`ifdef CFG_PARITY_EN
  localparam int FB = 18;
`else
  localparam int FB = 17;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  lut_cfg_loader_if #(.NUM_LP(NUM_LP)) bus ();
  lut_cfg_loader #(.NUM_LP(NUM_LP), .SYNC_WORD(8'hA5)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  slot;
    logic [15:0] lut;
    logic        sw;
  } commit_t;

  commit_t              exp_q[$];
  logic [16*NUM_LP-1:0] m_lut = '0;
  logic [NUM_LP-1:0]    m_sw  = '0;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_start = 0;
  int done_cyc = -1;
  int pulse_cnt = 0;
  bit prgm_low_seen = 1'b0;
  logic done_d = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Commit monitor: each strobe must match the oldest expected frame.
  initial forever begin
    commit_t e;
    @(negedge clk);
    if (bus.prgm_b === 1'b0) prgm_low_seen = 1'b1;
    if (bus.done === 1'b1 && done_d !== 1'b1) done_cyc = cyc;
    done_d = bus.done;
    if (bus.done === 1'b1 && bus.err === 1'b1) begin
      miscompares++;
      $display("FAIL done_err_both: done=%b err=%b, required not both 1", bus.done, bus.err);
    end
    if (bus.CLB_prgm_b === 1'b0) begin
      pulse_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL clb_pulse: unexpected commit strobe at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.look_up_t[16*e.slot +: 16] !== e.lut || bus.switch[e.slot] !== e.sw) begin
          miscompares++;
          $display("FAIL commit_slot%0d: got lut=%h sw=%b, required lut=%h sw=%b", e.slot,
                   bus.look_up_t[16*e.slot +: 16], bus.switch[e.slot], e.lut, e.sw);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  task automatic send_bit(input logic b, input bit gaps);
    if (gaps) begin
      int k;
      k = $urandom_range(0, 3);
      repeat (k) begin
        bus.cfg_valid = 1'b0;
        bus.cfg_bit   = 1'($urandom);
        @(negedge clk);
      end
    end
    bus.cfg_valid = 1'b1;
    bus.cfg_bit   = b;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gaps);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gaps);
  endtask

  task automatic send_frame(input int slot, input logic [15:0] lut, input logic sw,
                            input bit gaps, input bit bad_par);
    logic [16:0] data;
    data = {lut, sw};
    if (!bad_par) begin
      exp_q.push_back('{slot: 8'(slot), lut: lut, sw: sw});
      m_lut[16*slot +: 16] = lut;
      m_sw[slot] = sw;
    end
    for (int i = 16; i >= 0; i--) send_bit(data[i], gaps);
`ifdef CFG_PARITY_EN
    send_bit((^data) ^ bad_par, gaps);
`endif
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t_start   = cyc;
    done_cyc  = -1;
    pulse_cnt = 0;
    prgm_low_seen = 1'b0;
  endtask

  task automatic test_reset();
    logic [16*NUM_LP+NUM_LP+4:0] got;
    bus.start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_bit = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    got = {bus.look_up_t, bus.switch, bus.prgm_b, bus.CLB_prgm_b, bus.busy, bus.done, bus.err};
    vectors++;
    if (got !== {{(16*NUM_LP+NUM_LP){1'b0}}, 5'b11000}) begin
      miscompares++;
      $display("FAIL reset_vals: got %h, required %h", got, {{(16*NUM_LP+NUM_LP){1'b0}}, 5'b11000});
    end
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.cfg_valid = 1'($urandom);
      bus.cfg_bit   = 1'($urandom);
      @(negedge clk);
    end
    bus.cfg_valid = 1'b0;
    #1;
    got = {bus.look_up_t, bus.switch, bus.prgm_b, bus.CLB_prgm_b, bus.busy, bus.done, bus.err};
    vectors++;
    if (got !== {{(16*NUM_LP+NUM_LP){1'b0}}, 5'b11000} || prgm_low_seen) begin
      miscompares++;
      $display("FAIL idle_toggle: got %h prgm_low=%b, required idle reset values", got, prgm_low_seen);
    end
  endtask

  task automatic test_basic_load();
    do_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'd2, 1'b0);
    send_frame(0, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    send_frame(1, 16'h1234, 1'b0, 1'b0, 1'b0);
    bus.cfg_valid = 1'b0;
    #1;
    vectors++;
    if (done_cyc - t_start + 1 != 1 + 8 + 8 + 2*FB) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d cycles, required %0d", done_cyc - t_start + 1, 1 + 16 + 2*FB);
    end
    vectors++;
    if ({bus.done, bus.err, bus.busy, bus.prgm_b, prgm_low_seen} !== 5'b10011) begin
      miscompares++;
      $display("FAIL basic_status: done/err/busy/prgm_b/prgm_low=%b, required 10011",
               {bus.done, bus.err, bus.busy, bus.prgm_b, prgm_low_seen});
    end
    vectors++;
    if (bus.look_up_t[31:0] !== 32'h1234_BEEF || bus.switch[1:0] !== 2'b01) begin
      miscompares++;
      $display("FAIL basic_slots: got %h sw=%b, required 1234beef sw=01", bus.look_up_t[31:0], bus.switch[1:0]);
    end
    vectors++;
    if (pulse_cnt != 2) begin
      miscompares++;
      $display("FAIL basic_pulses: got %0d, required 2", pulse_cnt);
    end
  endtask

  task automatic test_sync_gaps();
    do_start();
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    bus.cfg_valid = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.prgm_b} !== 3'b101) begin
      miscompares++;
      $display("FAIL junk_no_sync: busy/done/prgm_b=%b, required 101", {bus.busy, bus.done, bus.prgm_b});
    end
    send_byte(8'hA5, 1'b1);
    send_byte(8'd2, 1'b1);
    send_frame(0, 16'hBEEF, 1'b1, 1'b1, 1'b0);
    send_frame(1, 16'h1234, 1'b0, 1'b1, 1'b0);
    bus.cfg_valid = 1'b0;
    #1;
    vectors++;
    if (bus.done !== 1'b1 || bus.look_up_t[31:0] !== 32'h1234_BEEF || bus.switch[1:0] !== 2'b01 || pulse_cnt != 2) begin
      miscompares++;
      $display("FAIL gap_load: done=%b slots=%h sw=%b pulses=%0d, required 1 1234beef 01 2",
               bus.done, bus.look_up_t[31:0], bus.switch[1:0], pulse_cnt);
    end
  endtask

  task automatic test_bad_count();
    logic [7:0] nvals [2];
    nvals[0] = 8'd0;
    nvals[1] = 8'(NUM_LP + 1);
    for (int j = 0; j < 2; j++) begin
      do_start();
      send_byte(8'hA5, 1'b0);
      send_byte(nvals[j], 1'b0);
      bus.cfg_valid = 1'b0;
      #1;
      vectors++;
      if ({bus.err, bus.done, bus.busy, prgm_low_seen} !== 4'b1000 || bus.look_up_t !== m_lut) begin
        miscompares++;
        $display("FAIL bad_count_n%0d: err/done/busy/prgm_low=%b lut_ok=%b, required 1000 and unchanged",
                 nvals[j], {bus.err, bus.done, bus.busy, prgm_low_seen}, bus.look_up_t === m_lut);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [16*NUM_LP+NUM_LP+4:0] got;
    do_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'd3, 1'b0);
    send_frame(0, 16'hCAFE, 1'b1, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0);
    bus.cfg_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    got = {bus.look_up_t, bus.switch, bus.prgm_b, bus.CLB_prgm_b, bus.busy, bus.done, bus.err};
    vectors++;
    if (got !== {{(16*NUM_LP+NUM_LP){1'b0}}, 5'b11000}) begin
      miscompares++;
      $display("FAIL mid_reset: got %h, required all reset values", got);
    end
    m_lut = '0;
    m_sw  = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_reset_queue: %0d commits outstanding, required 0", exp_q.size());
    end
    do_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'd3, 1'b0);
    send_frame(0, 16'h1111, 1'b0, 1'b0, 1'b0);
    send_frame(1, 16'h2222, 1'b1, 1'b0, 1'b0);
    send_frame(2, 16'h3333, 1'b1, 1'b0, 1'b0);
    bus.cfg_valid = 1'b0;
    #1;
    vectors++;
    if (bus.done !== 1'b1 || bus.look_up_t !== m_lut || bus.switch !== m_sw || pulse_cnt != 3) begin
      miscompares++;
      $display("FAIL reload: done=%b lut=%h sw=%b pulses=%0d, required 1 %h %b 3",
               bus.done, bus.look_up_t, bus.switch, pulse_cnt, m_lut, m_sw);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] nb;
    do_start();
    send_byte(8'hA5, 1'b0);
    nb = 8'd1;
    for (int i = 7; i >= 0; i--) begin
      bus.start = (i == 4);
      send_bit(nb[i], 1'b0);
    end
    bus.start = 1'b0;
    send_frame(0, 16'hABCD, 1'b0, 1'b0, 1'b0);
    bus.cfg_valid = 1'b0;
    #1;
    vectors++;
    if (bus.done !== 1'b1 || bus.look_up_t !== m_lut || bus.switch !== m_sw) begin
      miscompares++;
      $display("FAIL start_while_busy: done=%b lut=%h, required 1 %h", bus.done, bus.look_up_t, m_lut);
    end
    @(negedge clk);
    do_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'(NUM_LP), 1'b0);
    for (int k = 0; k < NUM_LP; k++)
      send_frame(k, 16'($urandom), 1'($urandom), 1'b0, 1'b0);
    bus.cfg_valid = 1'b0;
    #1;
    vectors++;
    if (bus.done !== 1'b1 || bus.look_up_t !== m_lut || bus.switch !== m_sw || pulse_cnt != NUM_LP) begin
      miscompares++;
      $display("FAIL full_load: done=%b lut=%h sw=%b pulses=%0d, required 1 %h %b %0d",
               bus.done, bus.look_up_t, bus.switch, pulse_cnt, m_lut, m_sw, NUM_LP);
    end
    vectors++;
    if (done_cyc - t_start + 1 != 17 + NUM_LP*FB) begin
      miscompares++;
      $display("FAIL full_latency: got %0d cycles, required %0d", done_cyc - t_start + 1, 17 + NUM_LP*FB);
    end
  endtask

`ifdef CFG_PARITY_EN
  task automatic test_parity();
    do_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'd2, 1'b0);
    send_frame(0, 16'h5A5A, 1'b1, 1'b0, 1'b0);
    send_frame(1, 16'h0F0F, 1'b0, 1'b0, 1'b1);
    bus.cfg_valid = 1'b0;
    #1;
    vectors++;
    if ({bus.err, bus.done, bus.busy, bus.prgm_b} !== 4'b1001 || pulse_cnt != 1) begin
      miscompares++;
      $display("FAIL parity_status: err/done/busy/prgm_b=%b pulses=%0d, required 1001 1",
               {bus.err, bus.done, bus.busy, bus.prgm_b}, pulse_cnt);
    end
    vectors++;
    if (bus.look_up_t !== m_lut || bus.switch !== m_sw) begin
      miscompares++;
      $display("FAIL parity_slots: got %h sw=%b, required %h sw=%b", bus.look_up_t, bus.switch, m_lut, m_sw);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_sync_gaps();
    test_bad_count();
    test_reset_mid();
    test_back_to_back();
`ifdef CFG_PARITY_EN
    test_parity();
`endif
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_queue: %0d commits never seen, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
